// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the memory stage: load/store size codes and LSU state.
package mips_cpu_pkg;

    localparam logic [2:0] LC_LB   = 3'b000;
    localparam logic [2:0] LC_LBU  = 3'b001;
    localparam logic [2:0] LC_LH   = 3'b010;
    localparam logic [2:0] LC_LHU  = 3'b011;
    localparam logic [2:0] LC_RSVD = 3'b100;
    localparam logic [2:0] LC_LW   = 3'b101;
    localparam logic [2:0] LC_LWL  = 3'b110;
    localparam logic [2:0] LC_LWR  = 3'b111;

    localparam logic [1:0] SS_B    = 2'b00;
    localparam logic [1:0] SS_H    = 2'b01;
    localparam logic [1:0] SS_W    = 2'b10;
    localparam logic [1:0] SS_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } lsu_state_t;

endpackage

// File: rtl/mips_cpu_lsu_format.sv
// Combinational load-data formatter: byte/halfword extension and LWL/LWR merge.
// Zero latency; no flow control (pure function of its inputs).
module mips_cpu_lsu_format
    import mips_cpu_pkg::*;
(
    input  logic [2:0]  loadcontrol,
    input  logic [1:0]  k,
    input  logic [31:0] w,
    input  logic [31:0] rt_old,
    output logic [31:0] rdata_next
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b          = w[{k, 3'b000} +: 8];
        h          = k[1] ? w[31:16] : w[15:0];
        rdata_next = w;
        case (loadcontrol)
            LC_LB:  rdata_next = {{24{b[7]}}, b};
            LC_LBU: rdata_next = {24'h0, b};
            LC_LH:  rdata_next = {{16{h[15]}}, h};
            LC_LHU: rdata_next = {16'h0, h};
            // Unaligned-word halves: memory bytes land at the top (LWL) or bottom (LWR) of rt.
            LC_LWL: begin
                case (k)
                    2'd0:    rdata_next = {w[7:0],  rt_old[23:0]};
                    2'd1:    rdata_next = {w[15:0], rt_old[15:0]};
                    2'd2:    rdata_next = {w[23:0], rt_old[7:0]};
                    default: rdata_next = w;
                endcase
            end
            LC_LWR: begin
                case (k)
                    2'd0:    rdata_next = w;
                    2'd1:    rdata_next = {rt_old[31:24], w[31:8]};
                    2'd2:    rdata_next = {rt_old[31:16], w[31:16]};
                    default: rdata_next = {rt_old[31:8],  w[31:24]};
                endcase
            end
            default: rdata_next = w;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one data-bus transaction per memory instruction, pipeline stalled meanwhile.
// Latency 2 cycles to done plus one per waitrequest cycle; bus held stable under waitrequest.
// LSU_ALIGN_CHECK_EN enables misaligned halfword/word detection (err pulse, no bus access).
module mips_cpu_lsu
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        loadcontrol,
    input  logic [1:0]        store_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rt_old,
    output logic              stall,
    output logic              done,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata
);

    lsu_state_t  state;
    logic [2:0]  lc_q;
    logic [1:0]  k_q;
    logic [31:0] rt_q;
    logic        load_q;

    logic        accept;
    logic        misalign;
    logic        bad;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [31:0] rdata_next;

    always_comb begin
        accept   = (state == ST_IDLE) && req_valid && (mem_read || mem_write);
        misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        if (mem_write)
            misalign = ((store_size == SS_H) && addr[0]) ||
                       ((store_size == SS_W) && (addr[1:0] != 2'b00));
        else
            misalign = (((loadcontrol == LC_LH) || (loadcontrol == LC_LHU)) && addr[0]) ||
                       ((loadcontrol == LC_LW) && (addr[1:0] != 2'b00));
`endif
        bad   = (mem_write ? (store_size == SS_RSVD) : (loadcontrol == LC_RSVD)) || misalign;
        err   = accept && bad;
        stall = accept || (state == ST_BUS);
    end

    always_comb begin
        be_next = 4'b0000;
        wd_next = 32'h0;
        if (mem_write) begin
            case (store_size)
                SS_B: begin
                    be_next = 4'b0001 << addr[1:0];
                    wd_next = {4{wdata[7:0]}};
                end
                SS_H: begin
                    be_next = addr[1] ? 4'b1100 : 4'b0011;
                    wd_next = {2{wdata[15:0]}};
                end
                SS_W: begin
                    be_next = 4'b1111;
                    wd_next = wdata;
                end
                default: ;
            endcase
        end else begin
            case (loadcontrol)
                LC_LB, LC_LBU: be_next = 4'b0001 << addr[1:0];
                LC_LH, LC_LHU: be_next = addr[1] ? 4'b1100 : 4'b0011;
                LC_LW:         be_next = 4'b1111;
                LC_LWL:        be_next = 4'b1111 >> (2'd3 - addr[1:0]);
                LC_LWR:        be_next = 4'b1111 << addr[1:0];
                default: ;
            endcase
        end
    end

    mips_cpu_lsu_format u_format (
        .loadcontrol (lc_q),
        .k           (k_q),
        .w           (avm_readdata),
        .rt_old      (rt_q),
        .rdata_next  (rdata_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            lc_q           <= 3'b000;
            k_q            <= 2'b00;
            rt_q           <= 32'h0;
            load_q         <= 1'b0;
            done           <= 1'b0;
            rdata_valid    <= 1'b0;
            rdata          <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'b0000;
            avm_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done        <= 1'b0;
                    rdata_valid <= 1'b0;
                    if (accept) begin
                        lc_q   <= loadcontrol;
                        k_q    <= addr[1:0];
                        rt_q   <= rt_old;
                        load_q <= !mem_write;
                        // Rejected accesses skip the bus but still retire through DONE.
                        if (bad) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state          <= ST_BUS;
                            avm_read       <= !mem_write;
                            avm_write      <= mem_write;
                            avm_address    <= {addr[ADDR_W-1:2], 2'b00};
                            avm_byteenable <= be_next;
                            avm_writedata  <= wd_next;
                        end
                    end
                end
                ST_BUS: begin
                    if (!avm_waitrequest) begin
                        if (load_q)
                            rdata <= rdata_next;
                        rdata_valid    <= load_q;
                        done           <= 1'b1;
                        avm_read       <= 1'b0;
                        avm_write      <= 1'b0;
                        avm_address    <= '0;
                        avm_byteenable <= 4'b0000;
                        avm_writedata  <= '0;
                        state          <= ST_DONE;
                    end
                end
                default: begin
                    done        <= 1'b0;
                    rdata_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
